// File: rtl/alu_operand_stage_pkg.sv
// Shared RV32I decode parameters: opcodes, funct3 codes, register field positions
// and the operand-usage decode helper used by the operand stage and the ALU.
package alu_operand_stage_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011
    } opcode_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic              use_rs1;
        logic              use_rs2;
        logic              write_rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } dec_t;

    function automatic dec_t decode(input logic [XLEN-1:0] instr);
        dec_t d;
        d.rs1      = instr[RS1_LSB +: REG_AW];
        d.rs2      = instr[RS2_LSB +: REG_AW];
        d.rd       = instr[RD_LSB +: REG_AW];
        d.use_rs1  = 1'b0;
        d.use_rs2  = 1'b0;
        d.write_rd = 1'b0;
        case (instr[6:0])
            OPC_OP:     begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.write_rd = 1'b1; end
            OPC_OP_IMM: begin d.use_rs1 = 1'b1; d.write_rd = 1'b1; end
            OPC_LUI:    d.write_rd = 1'b1;
            OPC_AUIPC:  d.write_rd = 1'b1;
            OPC_JAL:    d.write_rd = 1'b1;
            OPC_JALR:   begin d.use_rs1 = 1'b1; d.write_rd = 1'b1; end
            OPC_BRANCH: begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OPC_LOAD:   begin d.use_rs1 = 1'b1; d.write_rd = 1'b1; end
            OPC_STORE:  begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            default:    ;
        endcase
        // x0 is never a real destination, so it is never tracked as written
        if (d.rd == '0) d.write_rd = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/alu_operand_stage_regfile_2r1w.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero; synchronous active-low reset clears every register.
module regfile_2r1w
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_operand_stage.sv
// RV32I operand stage: register read, busy scoreboard, one-entry output register.
// Define OPERAND_BYPASS_EN to forward a same-cycle writeback into the operands.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instruction,
    output logic [XLEN-1:0]   out_op_a,
    output logic [XLEN-1:0]   out_op_b,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [NUM_REGS-1:0] dbg_busy
);

    dec_t                dec;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [XLEN-1:0]     rf_rd1;
    logic [XLEN-1:0]     rf_rd2;
    logic                fwd_rs1;
    logic                fwd_rs2;
    logic                fwd_rd;
    logic                hazard;
    logic                transfer;
    logic [XLEN-1:0]     op_a_next;
    logic [XLEN-1:0]     op_b_next;

    assign dec = decode(in_instruction);

    regfile_2r1w u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_valid),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (dec.rs1),
        .raddr2 (dec.rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

`ifdef OPERAND_BYPASS_EN
    assign fwd_rs1 = wb_valid && (wb_rd == dec.rs1) && (dec.rs1 != '0);
    assign fwd_rs2 = wb_valid && (wb_rd == dec.rs2) && (dec.rs2 != '0);
    assign fwd_rd  = wb_valid && (wb_rd == dec.rd)  && (dec.rd  != '0);
`else
    assign fwd_rs1 = 1'b0;
    assign fwd_rs2 = 1'b0;
    assign fwd_rd  = 1'b0;
`endif

    assign hazard = (dec.use_rs1  && busy[dec.rs1] && !fwd_rs1) ||
                    (dec.use_rs2  && busy[dec.rs2] && !fwd_rs2) ||
                    (dec.write_rd && busy[dec.rd]  && !fwd_rd);

    // Handshake: a beat moves on a rising edge where valid && ready on that side.
    // in_ready never depends on in_valid; out_* hold while out_valid && !out_ready.
    assign in_ready = rst_n && (!out_valid || out_ready) && !hazard;
    assign transfer = in_valid && in_ready;

    assign op_a_next = !dec.use_rs1 ? '0 : (fwd_rs1 ? wb_data : rf_rd1);
    assign op_b_next = !dec.use_rs2 ? '0 : (fwd_rs2 ? wb_data : rf_rd2);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wb_valid) clr_mask[wb_rd] = 1'b1;
        if (transfer && dec.write_rd) set_mask[dec.rd] = 1'b1;
    end

    // Set wins over a same-edge clear so a WAW successor keeps the register busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_op_a        <= '0;
            out_op_b        <= '0;
        end else if (transfer) begin
            out_valid       <= 1'b1;
            out_instruction <= in_instruction;
            out_op_a        <= op_a_next;
            out_op_b        <= op_b_next;
        end else if (out_ready) begin
            out_valid       <= 1'b0;
        end
    end

    assign dbg_busy = busy;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one clock and one reset: clock is clk, reset is rst_n; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 in_valid  input  1  upstream instruction available.
REQ-005 in_ready  output  1  block accepts in_instruction this cycle.
REQ-006 in_instruction  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  registered instruction/operands valid for the ALU.
REQ-008 out_ready  input  1  ALU/downstream consumes the output this cycle.
REQ-009 out_instruction  output  32  registered copy of the accepted instruction.
REQ-010 out_op_a, out_op_b  output  32 each  registered rs1/rs2 values.
REQ-011 wb_valid  input  1  writeback strobe from the ALU result path.
REQ-012 wb_rd  input  5  writeback destination register.
REQ-013 wb_data  input  32  writeback value.

Function
REQ-014 The block SHALL hold a 32x32 register file; x0 reads 0 and writes to x0 are discarded.
REQ-015 Writeback SHALL update the register file at the clk edge where wb_valid=1.
REQ-016 rs1 is used by OP, OP_IMM, BRANCH, LOAD, STORE and JALR; rs2 is used by OP, BRANCH and STORE; an unused operand is zero on out_op_a/out_op_b.
REQ-017 rd is written by OP, OP_IMM, LUI, AUIPC, JAL, JALR and LOAD when rd!=0.
REQ-018 A 32-bit scoreboard SHALL mark busy[rd] on acceptance of a writing instruction and clear it at the edge where wb_valid=1 with that wb_rd; busy[0] is constant 0.
REQ-019 Set and clear of the same busy bit in the same cycle SHALL leave it set.
REQ-020 Hazard SHALL be raised when a used rs1/rs2 or the written rd is busy, subject to REQ-029/REQ-030.
REQ-021 in_ready SHALL equal (!out_valid || out_ready) && !hazard; a transfer occurs when in_valid && in_ready.
REQ-022 Latency SHALL be one cycle: out_valid rises at the edge following a transfer.
REQ-023 out_* SHALL hold stable while out_valid && !out_ready.
REQ-024 out_valid SHALL clear at the edge where out_ready=1 and no new transfer occurs; back-to-back transfers sustain one instruction per cycle.
REQ-025 wb_valid for a register that is not busy SHALL still write the register file.

Reset
REQ-026 While rst_n=0 at an edge: out_valid=0, all busy bits=0, all registers=0, out_instruction/out_op_a/out_op_b=0.
REQ-027 in_ready SHALL be 0 in any cycle where rst_n=0; a transfer or writeback presented during reset is dropped.

Configuration
REQ-028 Macro OPERAND_BYPASS_EN selects same-cycle writeback forwarding.
REQ-029 With OPERAND_BYPASS_EN defined: when wb_valid && wb_rd==rsN!=0 in the accepting cycle, busy on that rsN (and on rd for WAW) is ignored and wb_data is captured as the operand.
REQ-030 Without OPERAND_BYPASS_EN: no forwarding; the instruction stalls until the cycle after the writeback edge and then reads the register file.

Structure
REQ-031 Opcode, funct3 constants and the rs1/rs2/rd field positions SHALL live in the shared params package used by the ALU.
REQ-032 The register file SHALL be sub-module regfile_2r1w (two combinational read ports, one synchronous write port, x0 hardwired).

Verification
REQ-033 Reset, then in_instruction ADDI x1,x0,5 (0x00500093), out_ready=1 -> out_valid next cycle, out_op_a=0, busy[1]=1.
REQ-034 Then wb_valid=1, wb_rd=1, wb_data=5; next ADD x2,x1,x1 -> with bypass accepted same cycle, out_op_a=out_op_b=5; without bypass in_ready=0 for one cycle, then out_op_a=out_op_b=5.
REQ-035 out_ready=0 with out_valid=1 -> in_ready=0, out_* unchanged over 3 cycles; out_ready=1 -> next instruction accepted.
REQ-036 wb_valid=1, wb_rd=0, wb_data=0xDEADBEEF, then ADD x3,x0,x0 -> out_op_a=out_op_b=0.
REQ-037 rst_n=0 asserted while out_valid=1 and busy[5]=1 -> next cycle out_valid=0, busy all 0, x5 reads 0.
REQ-038 Issue ADDI x4 then ADDI x4 (WAW) with no writeback -> second stalls until wb_valid, wb_rd=4; busy[4] remains 1 after same-cycle clear/set.
